// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command frame decoder.
package uart_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_CHK = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_LEN,
      S_PAY,
      S_CHK,
      S_OUT
   } state_t;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte idle counter; expire fires on the idle cycle that brings the count to TIMEOUT-1.
module frame_timeout #(
   parameter int TIMEOUT = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + CW'(1);
   end

   // The FSM registers its abort on this edge, so err_tick lands just as the count hits TIMEOUT-1.
   assign expire = en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame decoder behind the UART RX FIFO: SYNC, CMD, LEN, payload, XOR checksum,
// delivered over valid/ready with single-cycle error pulses.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int MAX_LEN = 4,
   parameter int TIMEOUT = 100000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_empty,
   input  logic [7:0]             r_data,
   output logic                   rd_uart,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [7:0]             cmd_code,
   output logic [3:0]             cmd_len,
   output logic [8*MAX_LEN-1:0]   cmd_data,
   output logic                   err_tick,
   output logic [1:0]             err_code,
   output logic                   busy
);

   localparam int DW = 8 * MAX_LEN;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t        state_q, state_d;
   logic [7:0]    code_q, code_d;
   logic [7:0]    xor_q, xor_d;
   logic [3:0]    len_q, len_d;
   logic [3:0]    idx_q, idx_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          err_tick_q, err_tick_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          busy_q, busy_d;

   logic pop;
   logic active;
   logic expire;

   assign active  = state_q inside {S_CMD, S_LEN, S_PAY, S_CHK};
   assign pop     = reset && !rx_empty && (state_q != S_OUT);
   assign rd_uart = pop;

   frame_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (pop || !active),
      .en     (active && rx_empty),
      .expire (expire)
   );

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      xor_d      = xor_q;
      len_d      = len_q;
      idx_d      = idx_q;
      data_d     = data_q;
      valid_d    = valid_q;
      err_tick_d = 1'b0;
      err_code_d = err_code_q;

      // Expiry only happens on an empty cycle, so no byte is ever popped and lost here.
      if (active && expire) begin
         err_tick_d = 1'b1;
         err_code_d = ERR_TMO;
         state_d    = S_HUNT;
      end else begin
         case (state_q)
            S_HUNT: begin
               if (pop && (r_data == SYNC_BYTE))
                  state_d = S_CMD;
            end
            S_CMD: begin
               if (pop) begin
                  code_d  = r_data;
                  xor_d   = r_data;
                  data_d  = '0;
                  state_d = S_LEN;
               end
            end
            S_LEN: begin
               if (pop) begin
                  len_d = r_data[3:0];
                  xor_d = xor_q ^ r_data;
                  idx_d = '0;
                  if (r_data > MAX_LEN_B) begin
                     err_tick_d = 1'b1;
                     err_code_d = ERR_LEN;
                     state_d    = S_HUNT;
                  end else if (r_data == 8'h00) begin
                     state_d = S_CHK;
                  end else begin
                     state_d = S_PAY;
                  end
               end
            end
            S_PAY: begin
               if (pop) begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     if (idx_q == 4'(i))
                        data_d[i*8 +: 8] = r_data;
                  end
                  xor_d = xor_q ^ r_data;
                  idx_d = idx_q + 4'd1;
                  if (idx_q == (len_q - 4'd1))
                     state_d = S_CHK;
               end
            end
            S_CHK: begin
               if (pop) begin
                  if (r_data == xor_q) begin
                     valid_d = 1'b1;
                     state_d = S_OUT;
                  end else begin
                     err_tick_d = 1'b1;
                     err_code_d = ERR_CHK;
                     state_d    = S_HUNT;
                  end
               end
            end
            S_OUT: begin
               if (cmd_ready) begin
                  valid_d = 1'b0;
                  state_d = S_HUNT;
               end
            end
            default: state_d = S_HUNT;
         endcase
      end

      busy_d = (state_d != S_HUNT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_HUNT;
         code_q     <= '0;
         xor_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_tick_q <= 1'b0;
         err_code_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         xor_q      <= xor_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_tick_q <= err_tick_d;
         err_code_q <= err_code_d;
         busy_q     <= busy_d;
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_code  = code_q;
   assign cmd_len   = len_q;
   assign cmd_data  = data_q;
   assign err_tick  = err_tick_q;
   assign err_code  = err_code_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a queue models the FWFT RX FIFO, expected
// frames and error codes are queued at stimulus time and checked as the DUT emits them.
module tb_uart_cmd_parser;

   localparam int MAX_LEN = 4;
   localparam int TIMEOUT = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 rx_empty = 1'b1;
   logic [7:0]           r_data = 8'h00;
   logic                 cmd_ready = 1'b1;
   logic                 rd_uart;
   logic                 cmd_valid;
   logic [7:0]           cmd_code;
   logic [3:0]           cmd_len;
   logic [8*MAX_LEN-1:0] cmd_data;
   logic                 err_tick;
   logic [1:0]           err_code;
   logic                 busy;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_empty  (rx_empty),
      .r_data    (r_data),
      .rd_uart   (rd_uart),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_code  (cmd_code),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .err_tick  (err_tick),
      .err_code  (err_code),
      .busy      (busy)
   );

   typedef struct {
      logic [7:0]  code;
      logic [3:0]  len;
      logic [31:0] data;
   } frame_t;

   logic [7:0] fifo[$];
   frame_t     exp_frames[$];
   logic [1:0] exp_errs[$];

   int chk_cnt = 0;
   int err_cnt = 0;
   int pop_cnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic refresh();
      rx_empty = (fifo.size() == 0);
      r_data   = rx_empty ? 8'h00 : fifo[0];
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo.push_back(b);
      refresh();
   endtask

   // One clock: sample the pop strobe before the edge, pop the FIFO model on it.
   task automatic tick();
      logic p;
      #1;
      p = rd_uart;
      @(posedge clk);
      if (p) begin
         pop_cnt++;
         if (fifo.size() > 0)
            void'(fifo.pop_front());
      end
      #1;
      refresh();
   endtask

   task automatic send_frame(input logic [7:0] code, input int len, input logic [31:0] pay,
                             input bit bad_chk);
      logic [7:0] x;
      logic [7:0] b;
      frame_t     f;
      f.code = code;
      f.len  = 4'(len);
      f.data = '0;
      push_byte(8'hA5);
      push_byte(code);
      push_byte(8'(len));
      x = code ^ 8'(len);
      for (int i = 0; i < len; i++) begin
         b = pay[i*8 +: 8];
         push_byte(b);
         x = x ^ b;
         f.data[i*8 +: 8] = b;
      end
      push_byte(bad_chk ? (x ^ 8'h01) : x);
      if (bad_chk)
         exp_errs.push_back(2'd2);
      else
         exp_frames.push_back(f);
   endtask

   task automatic drain(input int max_cycles, input bit rand_ready);
      int n;
      n = 0;
      while ((fifo.size() != 0 || exp_frames.size() != 0 || exp_errs.size() != 0 || busy)
             && n < max_cycles) begin
         if (rand_ready)
            cmd_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      cmd_ready = 1'b1;
      check_eq("drain_done", 64'(n < max_cycles), 64'd1);
   endtask

   always @(negedge clk) begin : monitor
      frame_t     f;
      logic [1:0] e;
      if (reset) begin
         if (cmd_valid && cmd_ready) begin
            if (exp_frames.size() == 0) begin
               check_eq("unexp_frame", 64'(cmd_valid), 64'd0);
            end else begin
               f = exp_frames.pop_front();
               check_eq("frame_code", 64'(cmd_code), 64'(f.code));
               check_eq("frame_len", 64'(cmd_len), 64'(f.len));
               check_eq("frame_data", 64'(cmd_data), 64'(f.data));
            end
         end
         if (err_tick) begin
            if (exp_errs.size() == 0) begin
               check_eq("unexp_err", 64'(err_tick), 64'd0);
            end else begin
               e = exp_errs.pop_front();
               check_eq("err_code", 64'(err_code), 64'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      int base;
      int sz;
      logic [7:0]  rc;
      logic [31:0] rp;

      // Reset with bytes waiting: nothing may be popped.
      push_byte(8'hA5);
      push_byte(8'h10);
      repeat (3) tick();
      check_eq("rst_rd_uart", 64'(rd_uart), 64'd0);
      check_eq("rst_pops", 64'(pop_cnt), 64'd0);
      check_eq("rst_valid", 64'(cmd_valid), 64'd0);
      check_eq("rst_code", 64'(cmd_code), 64'd0);
      check_eq("rst_len", 64'(cmd_len), 64'd0);
      check_eq("rst_data", 64'(cmd_data), 64'd0);
      check_eq("rst_err_tick", 64'(err_tick), 64'd0);
      check_eq("rst_err_code", 64'(err_code), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      fifo.delete();
      refresh();
      reset = 1'b1;
      tick();

      // Good frame: latency, pop count, held outputs.
      base = pop_cnt;
      send_frame(8'h10, 2, 32'h0000_1234, 1'b0);
      n = 0;
      while (!cmd_valid && n < 20) begin
         tick();
         n++;
      end
      check_eq("good_latency", 64'(n), 64'd6);
      drain(40, 1'b0);
      check_eq("good_pops", 64'(pop_cnt - base), 64'd6);
      check_eq("hold_code", 64'(cmd_code), 64'h10);
      check_eq("hold_len", 64'(cmd_len), 64'd2);
      check_eq("hold_data", 64'(cmd_data), 64'h1234);

      // Checksum error.
      send_frame(8'h10, 2, 32'h0000_1234, 1'b1);
      n = 0;
      while (!err_tick && n < 20) begin
         tick();
         n++;
      end
      check_eq("chk_err_seen", 64'(err_tick), 64'd1);
      tick();
      check_eq("chk_busy_after", 64'(busy), 64'd0);
      check_eq("chk_no_valid", 64'(cmd_valid), 64'd0);
      check_eq("chk_tick_single", 64'(err_tick), 64'd0);
      drain(20, 1'b0);
      check_eq("chk_code_held", 64'(err_code), 64'd2);

      // Bad length, stray byte discarded, then zero-length frame.
      push_byte(8'hA5);
      push_byte(8'h20);
      push_byte(8'h05);
      exp_errs.push_back(2'd1);
      push_byte(8'h01);
      send_frame(8'h20, 0, 32'h0, 1'b0);
      drain(40, 1'b0);

      // Backpressure with a second frame queued behind.
      cmd_ready = 1'b0;
      send_frame(8'h33, 3, 32'h0003_0201, 1'b0);
      send_frame(8'h44, 4, 32'hDDCC_BBAA, 1'b0);
      n = 0;
      while (!cmd_valid && n < 20) begin
         tick();
         n++;
      end
      sz = fifo.size();
      repeat (10) begin
         tick();
         check_eq("bp_rd_uart", 64'(rd_uart), 64'd0);
         check_eq("bp_valid", 64'(cmd_valid), 64'd1);
         check_eq("bp_code", 64'(cmd_code), 64'h33);
         check_eq("bp_data", 64'(cmd_data), 64'h0003_0201);
      end
      check_eq("bp_fifo_kept", 64'(fifo.size()), 64'(sz));
      cmd_ready = 1'b1;
      drain(60, 1'b0);

      // Sync byte inside a frame is plain data.
      send_frame(8'h55, 1, 32'h0000_00A5, 1'b0);
      send_frame(8'h66, 4, 32'hA5A5_A5A5, 1'b0);
      drain(60, 1'b0);

      // Random frames with random consumer readiness.
      for (int k = 0; k < 8; k++) begin
         rc = 8'($urandom);
         rp = $urandom;
         send_frame(rc, int'($urandom_range(0, MAX_LEN)), rp, ($urandom_range(0, 3) == 0));
      end
      drain(400, 1'b1);

      // Inter-byte timeout.
      base = pop_cnt;
      push_byte(8'hA5);
      push_byte(8'h10);
      exp_errs.push_back(2'd3);
      n = 0;
      while (pop_cnt < base + 2 && n < 10) begin
         tick();
         n++;
      end
      n = 0;
      while (!err_tick && n < 100) begin
         tick();
         n++;
      end
      check_eq("tmo_cycles", 64'(n), 64'd15);
      drain(20, 1'b0);
      send_frame(8'h77, 1, 32'h0000_005A, 1'b0);
      drain(40, 1'b0);

      // Reset in the middle of a payload.
      base = pop_cnt;
      push_byte(8'hA5);
      push_byte(8'h66);
      push_byte(8'h03);
      push_byte(8'h01);
      push_byte(8'h02);
      n = 0;
      while (pop_cnt < base + 5 && n < 20) begin
         tick();
         n++;
      end
      check_eq("pay_busy", 64'(busy), 64'd1);
      push_byte(8'h11);
      reset = 1'b0;
      tick();
      check_eq("mid_rd_uart", 64'(rd_uart), 64'd0);
      check_eq("mid_pops", 64'(pop_cnt - base), 64'd5);
      check_eq("mid_valid", 64'(cmd_valid), 64'd0);
      check_eq("mid_code", 64'(cmd_code), 64'd0);
      check_eq("mid_len", 64'(cmd_len), 64'd0);
      check_eq("mid_data", 64'(cmd_data), 64'd0);
      check_eq("mid_err_code", 64'(err_code), 64'd0);
      check_eq("mid_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      send_frame(8'h88, 2, 32'h0000_BEEF, 1'b0);
      drain(40, 1'b0);
      check_eq("post_rst_code", 64'(cmd_code), 64'h88);
      check_eq("post_rst_data", 64'(cmd_data), 64'hBEEF);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
